// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Widths, reset PC default and FSM encodings.
package ifu_fetch_pkg;

    localparam int unsigned IFU_CPU_WIDTH = 32;
    localparam int unsigned IFU_FQ_DEPTH  = 2;
    localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INST_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// Push on a full FIFO is accepted only together with a pop.
module fetch_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned W = 64,
    parameter int unsigned D = IFU_FQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic [$clog2(D):0]     o_count
);

    localparam int unsigned AW = $clog2(D);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == CW'(D));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !i_flush && !w_empty;
    assign w_push  = i_push && !i_flush && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(D); i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, memory request credit, redirect drain,
// and the {pc,inst} queue feeding the decode stage.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned          CPU_WIDTH = IFU_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(IFU_RESET_PC),
    parameter int unsigned          FQ_DEPTH  = IFU_FQ_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 ifu2mem_req,
    output logic [CPU_WIDTH-1:0] ifu2mem_addr,
    input  logic                 mem2ifu_gnt,
    input  logic                 mem2ifu_rvalid,
    input  logic [CPU_WIDTH-1:0] mem2ifu_rdata,
    input  logic                 exu2ifu_redirect,
    input  logic [CPU_WIDTH-1:0] exu2ifu_target,
    input  logic                 idu2ifu_ready,
    output logic                 ifu2idu_en,
    output logic [CPU_WIDTH-1:0] ifu2idu_pc,
    output logic [CPU_WIDTH-1:0] ifu2idu_inst
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

    ifu_state_e             r_state;
    ifu_state_e             w_state_nxt;
    logic [CPU_WIDTH-1:0]   r_pc;
    logic [CW-1:0]          r_outst;
    logic [CW-1:0]          r_discard;
    logic [CW-1:0]          w_outst_nxt;
    logic [CW-1:0]          w_discard_nxt;
    logic [CW-1:0]          w_qcount;
    logic [CW:0]            w_credit;
    logic                   w_acc;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_nempty;
    logic [CPU_WIDTH-1:0]   w_resp_pc;
    logic [2*CPU_WIDTH-1:0] w_qhead;

    assign w_credit     = {1'b0, r_outst} + {1'b0, w_qcount};
    assign ifu2mem_req  = (r_state == S_RUN) && enable && !exu2ifu_redirect
                          && (w_credit < (CW+1)'(FQ_DEPTH));
    assign ifu2mem_addr = r_pc;
    assign w_acc        = ifu2mem_req && mem2ifu_gnt;
    assign w_outst_nxt  = r_outst + CW'(w_acc) - CW'(mem2ifu_rvalid);

    // Responses are in order and pc advanced by 4 per grant,
    // so the oldest outstanding request sits r_outst words behind pc.
    assign w_resp_pc = r_pc - (CPU_WIDTH'(r_outst) << 2);
    assign w_push    = (r_state == S_RUN) && mem2ifu_rvalid
                       && !exu2ifu_redirect;
    assign w_nempty  = (w_qcount != '0);
    assign w_pop     = ifu2idu_en && idu2ifu_ready;

    fetch_fifo #(
        .W (2*CPU_WIDTH),
        .D (FQ_DEPTH)
    ) u_fq (
        .clk     (clk),
        .rst     (rst),
        .i_flush (exu2ifu_redirect),
        .i_push  (w_push),
        .i_wdata ({w_resp_pc, mem2ifu_rdata}),
        .i_pop   (w_pop),
        .o_rdata (w_qhead),
        .o_count (w_qcount)
    );

    assign ifu2idu_en   = w_nempty && !exu2ifu_redirect;
    assign ifu2idu_pc   = w_nempty ? w_qhead[2*CPU_WIDTH-1:CPU_WIDTH] : '0;
    assign ifu2idu_inst = w_nempty ? w_qhead[CPU_WIDTH-1:0] : '0;

    always_comb begin
        w_discard_nxt = r_discard;
        if (exu2ifu_redirect) begin
            w_discard_nxt = w_outst_nxt;
        end else if ((r_state == S_DRAIN) && mem2ifu_rvalid) begin
            w_discard_nxt = r_discard - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (exu2ifu_redirect && (w_outst_nxt != '0))
                    w_state_nxt = S_DRAIN;
                else if (!enable && (r_outst == '0))
                    w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (w_discard_nxt == '0) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_outst   <= '0;
            r_discard <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_outst   <= w_outst_nxt;
            r_discard <= w_discard_nxt;
            if (exu2ifu_redirect)
                r_pc <= {exu2ifu_target[CPU_WIDTH-1:2], 2'b00};
            else if (w_acc)
                r_pc <= r_pc + CPU_WIDTH'(4);
        end
    end

endmodule
